calc_sequenciador: RTL

//   Initiator side of the calculator interface: accepts a command stream
//   (load A, load B, execute, clear) over a valid/ready handshake and drives

---
 rtl/calc_sequenciador_if.sv | 31 +++
 rtl/calc_sequenciador.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/calc_sequenciador_if.sv
// Command and result handshake bundle between the front end, calc_sequenciador
// and the combinational calculator. The block under design uses the slave modport.
interface calc_sequenciador_if #(
  parameter int LARGURA = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_tipo;
  logic [LARGURA-1:0] cmd_dado;
  logic [LARGURA-1:0] entrada_A;
  logic [LARGURA-1:0] entrada_B;
  logic [2:0]         codigo;
  logic [LARGURA-1:0] saida;
  logic [LARGURA-1:0] resultado;
  logic               resultado_valid;
  logic               resultado_ready;
  logic               erro;
  logic [7:0]         contador_ops;

  modport master (
    output cmd_valid, cmd_tipo, cmd_dado, saida, resultado_ready,
    input  cmd_ready, entrada_A, entrada_B, codigo, resultado,
           resultado_valid, erro, contador_ops
  );

  modport slave (
    input  cmd_valid, cmd_tipo, cmd_dado, saida, resultado_ready,
    output cmd_ready, entrada_A, entrada_B, codigo, resultado,
           resultado_valid, erro, contador_ops
  );
endinterface

// File: rtl/calc_sequenciador.sv
// Command sequencer for the combinational calculator: loads operands, issues an
// opcode, waits SETTLE_CYCLES, captures saida and hands the result downstream.
module calc_sequenciador #(
  parameter int LARGURA       = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                clk,
  input logic                rst_n,
  calc_sequenciador_if.slave bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    OPCODE_MAX  = 3'b100;

  typedef enum logic [1:0] {
    CMD_LOAD_A = 2'b00,
    CMD_LOAD_B = 2'b01,
    CMD_EXEC   = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_tipo_e;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    ESPERA  = 2'b01,
    ENTREGA = 2'b10
  } estado_e;

  estado_e            r_estado;
  estado_e            w_estado_prox;
  logic [CW-1:0]      r_settle;
  logic [LARGURA-1:0] r_entrada_a;
  logic [LARGURA-1:0] r_entrada_b;
  logic [2:0]         r_codigo;
  logic [LARGURA-1:0] r_resultado;
  logic               r_resultado_valid;
  logic               r_erro;
  logic [7:0]         r_contador_ops;

  logic               w_cmd_ready;
  logic               w_load_a;
  logic               w_load_b;
  logic               w_clear;
  logic               w_exec;
  logic               w_capture;
  logic               w_consume;
  cmd_tipo_e          w_tipo;

  assign w_tipo = cmd_tipo_e'(bus.cmd_tipo);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and process ordering cannot change behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= OCIOSO;
    else        r_estado <= w_estado_prox;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_estado_prox = r_estado;
    w_cmd_ready   = 1'b0;
    w_load_a      = 1'b0;
    w_load_b      = 1'b0;
    w_clear       = 1'b0;
    w_exec        = 1'b0;
    w_capture     = 1'b0;
    w_consume     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          case (w_tipo)
            CMD_LOAD_A: w_load_a = 1'b1;
            CMD_LOAD_B: w_load_b = 1'b1;
            CMD_CLEAR:  w_clear  = 1'b1;
            CMD_EXEC: begin
              w_exec        = 1'b1;
              w_estado_prox = ESPERA;
            end
            default: ;
          endcase
        end
      end
      ESPERA: begin
        if (r_settle == '0) begin
          w_capture     = 1'b1;
          w_estado_prox = ENTREGA;
        end
      end
      ENTREGA: begin
        if (bus.resultado_ready) begin
          w_consume     = 1'b1;
          w_estado_prox = OCIOSO;
        end
      end
      default: w_estado_prox = OCIOSO;
    endcase
  end

  // Settle counter: loaded on EXEC, counts down while the calculator settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
    end else if (w_exec) begin
      r_settle <= SETTLE_INIT;
    end else if (r_estado == ESPERA && r_settle != '0) begin
      r_settle <= r_settle - CW'(1);
    end
  end

  // Operand and opcode registers; they persist across EXEC so a new EXEC
  // reuses the stored operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entrada_a <= '0;
      r_entrada_b <= '0;
      r_codigo    <= '0;
    end else if (w_clear) begin
      r_entrada_a <= '0;
      r_entrada_b <= '0;
      r_codigo    <= '0;
    end else begin
      if (w_load_a) r_entrada_a <= bus.cmd_dado;
      if (w_load_b) r_entrada_b <= bus.cmd_dado;
      if (w_exec)   r_codigo    <= bus.cmd_dado[2:0];
    end
  end

  // Result side: resultado and erro only move on capture or CLEAR, so they
  // stay stable while the result waits in ENTREGA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resultado       <= '0;
      r_resultado_valid <= 1'b0;
      r_erro            <= 1'b0;
      r_contador_ops    <= '0;
    end else begin
      if (w_clear) begin
        r_resultado <= '0;
        r_erro      <= 1'b0;
      end else if (w_capture) begin
        r_resultado    <= bus.saida;
        r_erro         <= (r_codigo > OPCODE_MAX);
        r_contador_ops <= r_contador_ops + 8'd1;
      end
      if (w_capture)      r_resultado_valid <= 1'b1;
      else if (w_consume) r_resultado_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready       = w_cmd_ready;
  assign bus.entrada_A       = r_entrada_a;
  assign bus.entrada_B       = r_entrada_b;
  assign bus.codigo          = r_codigo;
  assign bus.resultado       = r_resultado;
  assign bus.resultado_valid = r_resultado_valid;
  assign bus.erro            = r_erro;
  assign bus.contador_ops    = r_contador_ops;

endmodule
